apb_fifo_port: RTL and testbench
================================

// Module: apb_fifo_port
// PURPOSE
//  Parametrised APB3 slave giving a CPU push and pop access to one sync FIFO.
//  Second-generation FIFO front end: pop path, FSM-managed wait states on full/empty, bounded stall timeout with PSLVERR,
//  flush control, almost-full threshold with IRQ. Sits between APB bridge and FIFO core (FIFO is FWFT, head on fifo_rdata).
// PARAMETERS
//  DATA_W     32            FIFO word width, 1..32; prdata zero-extended
//  LEVEL_W    5             fifo_level width, 1..8 (depth <= 2**LEVEL_W - 1)
//  BASE_ADDR  32'h2000_0000 register window base; window = BASE_ADDR .. BASE_ADDR+0x0C
//  TIMEOUT    16            max wait cycles for a blocked push/pop before error, >= 2
// PORTS
//  clk          in   1        clock
//  rst_n        in   1        reset, asynchronous, active-low
//  psel         in   1        APB select
//  penable      in   1        APB enable
//  pwrite       in   1        1 = write, 0 = read
//  paddr        in   32       APB address
//  pwdata       in   32       APB write data
//  prdata       out  32       APB read data
//  pready       out  1        APB ready, registered
//  pslverr      out  1        APB error, valid only with pready
//  fifo_wr_en   out  1        push strobe, 1-cycle pulse
//  fifo_wdata   out  DATA_W   push data = pwdata[DATA_W-1:0]
//  fifo_rd_en   out  1        pop strobe, 1-cycle pulse
//  fifo_rdata   in   DATA_W   FIFO head word (FWFT)
//  fifo_full    in   1        FIFO full
//  fifo_empty   in   1        FIFO empty
//  fifo_level   in   LEVEL_W  FIFO occupancy
//  fifo_flush   out  1        FIFO clear, 1-cycle pulse
//  irq          out  1        registered: irq_en & (fifo_level >= thresh)
// BEHAVIOUR
//  Reset: every output 0; FSM IDLE; wait_cnt 0; irq_en 0; thresh all-ones (LEVEL_W bits).
//  Map (offset): 0x00 DATA  W = push, R = pop.
//                0x04 STATUS RO: [0] empty, [1] full, [2] almost_full, [LEVEL_W+7:8] level.
//                0x08 CTRL: [0] flush (W1 pulse, reads 0), [1] irq_en.
//                0x0C THRESH RW [LEVEL_W-1:0].
//  FSM IDLE -> CHECK -> RESP -> IDLE:
//   IDLE: on psel & !penable, register addr/dir/data; -> CHECK.
//   CHECK (penable=1): blocked = push & fifo_full, or pop & fifo_empty.
//     blocked: wait_cnt++, stay; at wait_cnt == TIMEOUT-1 -> RESP with error, no side effect.
//     not blocked: -> RESP; on that edge register the side effect (wr_en/rd_en/flush pulse), prdata, pslverr.
//   RESP: pready = 1 for exactly one cycle, wait_cnt cleared; -> IDLE.
//  Latency: unblocked transfer = setup + 2 access cycles (1 wait state); every extra blocked cycle adds 1.
//  Pop: prdata = {0, fifo_rdata} sampled at CHECK->RESP edge; fifo_rd_en asserted in the same cycle as pready.
//  Push: fifo_wr_en asserted in the RESP cycle with pready.
//  PSLVERR = 1 (no side effect, prdata = 0) for:
//    - paddr outside window or paddr[1:0] != 0
//    - write to STATUS
//    - stall timeout
//  Back-to-back: RESP -> IDLE, then the next setup cycle is accepted; no extra idle needed.
//  psel = 0 while in CHECK (protocol violation): -> IDLE, no side effect, no pready.
//  Flush while blocked push/pop is impossible (single outstanding transfer).
//  Flush write: fifo_flush pulse in the RESP cycle; a later blocked pop waits as normal.
//  Flush with irq_en = 1: irq is re-evaluated on the next edge from the updated level.
//  Push + pop simultaneity: none; one APB transfer at a time.
//  Reset mid-transfer: immediate return to reset values; the master must restart.
// STRUCTURE
//  Package apb_fifo_pkg: register offsets (OFS_DATA/STATUS/CTRL/THRESH), FSM state encoding (one-hot, 3 bits),
//  STATUS bit positions.
//  Sub-module apb_fifo_decode (combinational): paddr/pwrite -> reg select, err_addr, err_ro.
//  FSM, wait counter ($clog2(TIMEOUT) bits) and CTRL/THRESH registers stay in this module.
// TESTING
//  1. Reset, write DATA 0xA5A5_0001 to empty FIFO -> fifo_wr_en 1 cycle, fifo_wdata 0xA5A5_0001, pready on 2nd access cycle, pslverr 0.
//  2. Push 3 words, read STATUS -> prdata[0] = 0, prdata[1] = 0, level field = 3; pop 3 times -> same words in order, rd_en 1 pulse each.
//  3. fifo_full held, write DATA, TIMEOUT = 16 -> 16 wait cycles then pready with pslverr = 1, fifo_wr_en never asserted.
//  4. fifo_empty held 5 cycles, then head 0x1234 presented, during pop -> pready on cycle 7, prdata 0x1234, pslverr 0.
//  5. Bad access: read 0x2000_0010, write 0x2000_0004, read 0x2000_0002 -> each pslverr = 1, prdata = 0, no strobes.
//  6. Write THRESH = 2, CTRL = 0x2, push 2 words -> irq rises next edge; write CTRL = 0x3 -> fifo_flush pulse, irq falls once level = 0.

Source files
------------

// File: rtl/apb_fifo_pkg.sv
// Shared definitions for the APB FIFO front end: register map, FSM encoding,
// STATUS/CTRL bit positions and the captured-request payload.
package apb_fifo_pkg;

  localparam logic [3:0] OFS_DATA   = 4'h0;
  localparam logic [3:0] OFS_STATUS = 4'h4;
  localparam logic [3:0] OFS_CTRL   = 4'h8;
  localparam logic [3:0] OFS_THRESH = 4'hC;

  // Word index of each register inside the window
  localparam logic [1:0] SEL_DATA   = OFS_DATA[3:2];
  localparam logic [1:0] SEL_STATUS = OFS_STATUS[3:2];
  localparam logic [1:0] SEL_CTRL   = OFS_CTRL[3:2];
  localparam logic [1:0] SEL_THRESH = OFS_THRESH[3:2];

  localparam int unsigned STAT_EMPTY = 0;
  localparam int unsigned STAT_FULL  = 1;
  localparam int unsigned STAT_AFULL = 2;
  localparam int unsigned STAT_LEVEL = 8;

  localparam int unsigned CTRL_FLUSH  = 0;
  localparam int unsigned CTRL_IRQ_EN = 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b001,
    ST_CHECK = 3'b010,
    ST_RESP  = 3'b100
  } state_e;

  typedef struct packed {
    logic        write;
    logic        err;
    logic [1:0]  sel;
    logic [31:0] wdata;
  } apb_req_t;

endpackage

// File: rtl/apb_fifo_decode.sv
// Address decode for the FIFO port window: register select plus
// out-of-window/misaligned and read-only-write error flags.
module apb_fifo_decode
  import apb_fifo_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h2000_0000
) (
  input  logic [31:0] paddr,
  input  logic        pwrite,
  output logic [1:0]  reg_sel_c,
  output logic        err_addr_c,
  output logic        err_ro_c
);

  logic [31:0] offset_c;

  // Wrapping subtraction makes addresses below the base land far outside the window
  assign offset_c   = paddr - BASE_ADDR;
  assign reg_sel_c  = offset_c[3:2];
  assign err_addr_c = (offset_c > 32'(OFS_THRESH)) || (offset_c[1:0] != 2'b00);
  assign err_ro_c   = pwrite && (offset_c[3:0] == OFS_STATUS);

endmodule

// File: rtl/apb_fifo_port.sv
// APB3 slave giving push/pop access to a FWFT sync FIFO, with wait states on
// full/empty, bounded stall timeout, flush and almost-full interrupt.
module apb_fifo_port
  import apb_fifo_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned LEVEL_W   = 5,
  parameter logic [31:0] BASE_ADDR = 32'h2000_0000,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               psel,
  input  logic               penable,
  input  logic               pwrite,
  input  logic [31:0]        paddr,
  input  logic [31:0]        pwdata,
  output logic [31:0]        prdata,
  output logic               pready,
  output logic               pslverr,
  output logic               fifo_wr_en,
  output logic [DATA_W-1:0]  fifo_wdata,
  output logic               fifo_rd_en,
  input  logic [DATA_W-1:0]  fifo_rdata,
  input  logic               fifo_full,
  input  logic               fifo_empty,
  input  logic [LEVEL_W-1:0] fifo_level,
  output logic               fifo_flush,
  output logic               irq
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);

  state_e             state;
  state_e             state_nx;
  apb_req_t           req_q;
  logic [CNT_W-1:0]   wait_cnt;
  logic               irq_en;
  logic [LEVEL_W-1:0] thresh;

  logic [1:0]         dec_sel_c;
  logic               dec_err_addr_c;
  logic               dec_err_ro_c;

  logic               setup_c;
  logic               push_c;
  logic               pop_c;
  logic               blocked_c;
  logic               timeout_c;
  logic               almost_full_c;
  logic               finish_c;
  logic               ok_c;
  logic [31:0]        rd_mux_c;

  logic               pready_d;
  logic               pslverr_d;
  logic               wr_en_d;
  logic               rd_en_d;
  logic               flush_d;
  logic               ctrl_we_d;
  logic               thresh_we_d;
  logic [31:0]        prdata_d;

  apb_fifo_decode #(
    .BASE_ADDR (BASE_ADDR)
  ) u_decode (
    .paddr      (paddr),
    .pwrite     (pwrite),
    .reg_sel_c  (dec_sel_c),
    .err_addr_c (dec_err_addr_c),
    .err_ro_c   (dec_err_ro_c)
  );

  assign setup_c       = (state == ST_IDLE) && psel && !penable;
  assign push_c        = req_q.write && (req_q.sel == SEL_DATA) && !req_q.err;
  assign pop_c         = !req_q.write && (req_q.sel == SEL_DATA) && !req_q.err;
  assign blocked_c     = (push_c && fifo_full) || (pop_c && fifo_empty);
  assign timeout_c     = (wait_cnt == CNT_W'(TIMEOUT - 1));
  assign almost_full_c = (fifo_level >= thresh);

  // Request capture during the APB setup phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q <= '0;
    end else if (setup_c) begin
      req_q.write <= pwrite;
      req_q.err   <= dec_err_addr_c || dec_err_ro_c;
      req_q.sel   <= dec_sel_c;
      req_q.wdata <= pwdata;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:  if (setup_c) state_nx = ST_CHECK;
      ST_CHECK: begin
        if (!psel)                         state_nx = ST_IDLE;
        else if (!blocked_c || timeout_c)  state_nx = ST_RESP;
      end
      ST_RESP:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Output logic: everything decided on the CHECK->RESP edge
  always_comb begin
    pready_d    = 1'b0;
    pslverr_d   = 1'b0;
    wr_en_d     = 1'b0;
    rd_en_d     = 1'b0;
    flush_d     = 1'b0;
    ctrl_we_d   = 1'b0;
    thresh_we_d = 1'b0;
    prdata_d    = '0;
    rd_mux_c    = '0;

    case (req_q.sel)
      SEL_DATA:   rd_mux_c[DATA_W-1:0] = fifo_rdata;
      SEL_STATUS: begin
        rd_mux_c[STAT_EMPTY]             = fifo_empty;
        rd_mux_c[STAT_FULL]              = fifo_full;
        rd_mux_c[STAT_AFULL]             = almost_full_c;
        rd_mux_c[STAT_LEVEL +: LEVEL_W]  = fifo_level;
      end
      SEL_CTRL:   rd_mux_c[CTRL_IRQ_EN] = irq_en;
      SEL_THRESH: rd_mux_c[LEVEL_W-1:0] = thresh;
      default:    rd_mux_c = '0;
    endcase

    finish_c  = (state == ST_CHECK) && psel && (!blocked_c || timeout_c);
    ok_c      = finish_c && !blocked_c && !req_q.err;
    pready_d  = finish_c;
    pslverr_d = finish_c && (req_q.err || blocked_c);

    if (ok_c) begin
      wr_en_d     = push_c;
      rd_en_d     = pop_c;
      ctrl_we_d   = req_q.write && (req_q.sel == SEL_CTRL);
      thresh_we_d = req_q.write && (req_q.sel == SEL_THRESH);
      flush_d     = ctrl_we_d && req_q.wdata[CTRL_FLUSH];
      if (!req_q.write) prdata_d = rd_mux_c;
    end
  end

  // Stall counter: runs only while a push/pop is blocked, cleared otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if ((state == ST_CHECK) && psel && blocked_c && !timeout_c) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

  // Registered outputs and control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pready     <= 1'b0;
      pslverr    <= 1'b0;
      prdata     <= '0;
      fifo_wr_en <= 1'b0;
      fifo_rd_en <= 1'b0;
      fifo_flush <= 1'b0;
      fifo_wdata <= '0;
      irq        <= 1'b0;
      irq_en     <= 1'b0;
      thresh     <= '1;
    end else begin
      pready     <= pready_d;
      pslverr    <= pslverr_d;
      prdata     <= prdata_d;
      fifo_wr_en <= wr_en_d;
      fifo_rd_en <= rd_en_d;
      fifo_flush <= flush_d;
      irq        <= irq_en && almost_full_c;
      if (wr_en_d)     fifo_wdata <= req_q.wdata[DATA_W-1:0];
      if (ctrl_we_d)   irq_en     <= req_q.wdata[CTRL_IRQ_EN];
      if (thresh_we_d) thresh     <= req_q.wdata[LEVEL_W-1:0];
    end
  end

endmodule

// File: tb/tb_apb_fifo_port.sv
// Directed bench for apb_fifo_port: behavioural FIFO model on the core side,
// scoreboard queues for pushed and popped words.
module tb_apb_fifo_port;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned LEVEL_W = 5;
  localparam int unsigned TIMEOUT = 16;
  localparam logic [31:0] BASE    = 32'h2000_0000;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               psel, penable, pwrite;
  logic [31:0]        paddr, pwdata, prdata;
  logic               pready, pslverr;
  logic               fifo_wr_en, fifo_rd_en, fifo_flush, irq;
  logic [DATA_W-1:0]  fifo_wdata, fifo_rdata;
  logic               fifo_full, fifo_empty;
  logic [LEVEL_W-1:0] fifo_level;

  always #5 clk = ~clk;

  apb_fifo_port #(
    .DATA_W    (DATA_W),
    .LEVEL_W   (LEVEL_W),
    .BASE_ADDR (BASE),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .paddr      (paddr),
    .pwdata     (pwdata),
    .prdata     (prdata),
    .pready     (pready),
    .pslverr    (pslverr),
    .fifo_wr_en (fifo_wr_en),
    .fifo_wdata (fifo_wdata),
    .fifo_rd_en (fifo_rd_en),
    .fifo_rdata (fifo_rdata),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .fifo_level (fifo_level),
    .fifo_flush (fifo_flush),
    .irq        (irq)
  );

  // FWFT FIFO model, depth 16, plus a side door to inject a word
  logic [31:0] mem [0:15];
  logic [3:0]  wp, rp;
  logic [4:0]  cnt;
  logic        force_full = 1'b0;
  logic        inj_req    = 1'b0;
  logic [31:0] inj_data   = '0;

  assign fifo_rdata = mem[rp];
  assign fifo_level = cnt;
  assign fifo_empty = (cnt == 5'd0);
  assign fifo_full  = force_full || (cnt == 5'd16);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0; rp <= '0; cnt <= '0;
    end else if (fifo_flush) begin
      rp <= wp; cnt <= '0;
    end else begin
      if (fifo_wr_en || inj_req) begin
        mem[wp] <= fifo_wr_en ? fifo_wdata : inj_data;
        wp <= wp + 4'd1;
      end
      if (fifo_rd_en) rp <= rp + 4'd1;
      cnt <= cnt + 5'(fifo_wr_en || inj_req) - 5'(fifo_rd_en);
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Scoreboards
  logic [31:0] wr_exp_q [$];
  logic [31:0] rd_exp_q [$];
  int wr_cnt = 0, rd_cnt = 0, fl_cnt = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (fifo_wr_en) begin
        if (wr_exp_q.size() > 0) check("push_wdata", fifo_wdata, wr_exp_q.pop_front());
        else                     check("push_expected", 32'(wr_exp_q.size()), 32'd1);
        check("push_with_pready", 32'(pready), 32'd1);
      end
      if (fifo_rd_en) check("pop_with_pready", 32'(pready), 32'd1);
      wr_cnt += int'(fifo_wr_en);
      rd_cnt += int'(fifo_rd_en);
      fl_cnt += int'(fifo_flush);
    end
  end

  // One APB transfer; acc = access cycle in which pready was seen
  task automatic apb(input logic [31:0] a, input logic w, input logic [31:0] d,
                     output logic [31:0] rdat, output logic e, output int acc);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; paddr = a; pwrite = w; pwdata = d;
    @(negedge clk);
    penable = 1'b1;
    acc = 1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      acc++;
      if (pready) break;
    end
    check("pready_seen", 32'(pready), 32'd1);
    rdat = prdata;
    e    = pslverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  logic [31:0] rd;
  logic        err;
  int          acc;
  int          w0, r0, f0;

  initial begin
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pready",  32'(pready),     32'd0);
    check("rst_pslverr", 32'(pslverr),    32'd0);
    check("rst_prdata",  prdata,          32'd0);
    check("rst_wr_en",   32'(fifo_wr_en), 32'd0);
    check("rst_rd_en",   32'(fifo_rd_en), 32'd0);
    check("rst_flush",   32'(fifo_flush), 32'd0);
    check("rst_irq",     32'(irq),        32'd0);
    check("rst_wdata",   fifo_wdata,      32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    apb(BASE + 32'h4, 1'b0, '0, rd, err, acc);
    check("status_empty", rd, 32'h0000_0001);
    apb(BASE + 32'hC, 1'b0, '0, rd, err, acc);
    check("thresh_reset", rd, 32'h0000_001F);

    // Single push to empty FIFO
    w0 = wr_cnt;
    wr_exp_q.push_back(32'hA5A5_0001);
    apb(BASE, 1'b1, 32'hA5A5_0001, rd, err, acc);
    check("t1_latency", 32'(acc), 32'd2);
    check("t1_pslverr", 32'(err), 32'd0);
    check("t1_wr_pulses", 32'(wr_cnt - w0), 32'd1);

    r0 = rd_cnt;
    rd_exp_q.push_back(32'hA5A5_0001);
    apb(BASE, 1'b0, '0, rd, err, acc);
    check("t1_pop_data", rd, rd_exp_q.pop_front());
    check("t1_rd_pulses", 32'(rd_cnt - r0), 32'd1);

    // Push three, check STATUS, pop three in order
    for (int i = 0; i < 3; i++) begin
      wr_exp_q.push_back(32'(i + 1) * 32'h11);
      rd_exp_q.push_back(32'(i + 1) * 32'h11);
      apb(BASE, 1'b1, 32'(i + 1) * 32'h11, rd, err, acc);
    end
    apb(BASE + 32'h4, 1'b0, '0, rd, err, acc);
    check("t2_status", rd, 32'h0000_0300);
    r0 = rd_cnt;
    for (int i = 0; i < 3; i++) begin
      apb(BASE, 1'b0, '0, rd, err, acc);
      check("t2_pop_data", rd, rd_exp_q.pop_front());
      check("t2_pop_err", 32'(err), 32'd0);
    end
    check("t2_rd_pulses", 32'(rd_cnt - r0), 32'd3);
    check("t2_rd_q_empty", 32'(rd_exp_q.size()), 32'd0);

    // Push stalled on full until timeout
    force_full = 1'b1;
    w0 = wr_cnt;
    apb(BASE, 1'b1, 32'hDEAD_BEEF, rd, err, acc);
    check("t3_latency", 32'(acc), 32'(TIMEOUT + 1));
    check("t3_pslverr", 32'(err), 32'd1);
    check("t3_no_push", 32'(wr_cnt - w0), 32'd0);
    force_full = 1'b0;

    // Pop waits on empty for five access cycles, then head appears
    inj_data = 32'h0000_1234;
    rd_exp_q.push_back(32'h0000_1234);
    fork
      apb(BASE, 1'b0, '0, rd, err, acc);
      begin
        @(negedge clk);
        repeat (5) @(posedge clk);
        #1 inj_req = 1'b1;
        @(posedge clk);
        #1 inj_req = 1'b0;
      end
    join
    check("t4_latency", 32'(acc), 32'd7);
    check("t4_pop_data", rd, rd_exp_q.pop_front());
    check("t4_pslverr", 32'(err), 32'd0);

    // Bad accesses: no strobes, zero data
    w0 = wr_cnt; r0 = rd_cnt; f0 = fl_cnt;
    apb(BASE + 32'h10, 1'b0, '0, rd, err, acc);
    check("t5_oow_err", 32'(err), 32'd1);
    check("t5_oow_data", rd, 32'd0);
    apb(BASE + 32'h4, 1'b1, 32'hFFFF_FFFF, rd, err, acc);
    check("t5_ro_err", 32'(err), 32'd1);
    apb(BASE + 32'h2, 1'b0, '0, rd, err, acc);
    check("t5_align_err", 32'(err), 32'd1);
    check("t5_align_data", rd, 32'd0);
    apb(BASE - 32'h4, 1'b0, '0, rd, err, acc);
    check("t5_below_err", 32'(err), 32'd1);
    check("t5_no_strobes", 32'((wr_cnt - w0) + (rd_cnt - r0) + (fl_cnt - f0)), 32'd0);

    // Threshold IRQ and flush
    apb(BASE + 32'hC, 1'b1, 32'h2, rd, err, acc);
    check("t6_thresh_wr_err", 32'(err), 32'd0);
    apb(BASE + 32'h8, 1'b1, 32'h2, rd, err, acc);
    apb(BASE + 32'hC, 1'b0, '0, rd, err, acc);
    check("t6_thresh_rd", rd, 32'h2);
    wr_exp_q.push_back(32'hB1);
    apb(BASE, 1'b1, 32'hB1, rd, err, acc);
    @(posedge clk); #1;
    check("t6_irq_lvl1", 32'(irq), 32'd0);
    wr_exp_q.push_back(32'hB2);
    apb(BASE, 1'b1, 32'hB2, rd, err, acc);
    check("t6_irq_before", 32'(irq), 32'd0);
    @(posedge clk); #1;
    check("t6_irq_rise", 32'(irq), 32'd1);
    apb(BASE + 32'h4, 1'b0, '0, rd, err, acc);
    check("t6_status", rd, 32'h0000_0204);
    f0 = fl_cnt;
    apb(BASE + 32'h8, 1'b1, 32'h3, rd, err, acc);
    check("t6_flush_pulse", 32'(fl_cnt - f0), 32'd1);
    check("t6_irq_hold", 32'(irq), 32'd1);
    @(posedge clk); #1;
    check("t6_irq_fall", 32'(irq), 32'd0);
    apb(BASE + 32'h8, 1'b0, '0, rd, err, acc);
    check("t6_ctrl_rd", rd, 32'h2);
    apb(BASE + 32'h4, 1'b0, '0, rd, err, acc);
    check("t6_status_flushed", rd, 32'h0000_0001);

    // Pop after flush blocks as normal and times out
    r0 = rd_cnt;
    apb(BASE, 1'b0, '0, rd, err, acc);
    check("t6_pop_latency", 32'(acc), 32'(TIMEOUT + 1));
    check("t6_pop_err", 32'(err), 32'd1);
    check("t6_pop_data", rd, 32'd0);
    check("t6_no_pop", 32'(rd_cnt - r0), 32'd0);
    check("wr_q_drained", 32'(wr_exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
